// File: rtl/imem_port_arbiter.sv
// Arbiter sharing a single-port synchronous instruction memory between fetch (read-only)
// and a loader/debug port (read/write). Loader bursts are bounded so fetch always progresses.
module imem_port_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 33,
  parameter int MAX_BURST    = 16,
  parameter int HANDBACK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              arb_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int HW = $clog2(HANDBACK_CYC + 1);

  localparam logic [BW-1:0] BURST_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [HW-1:0] HB_ZERO    = {HW{1'b0}};
  localparam logic [HW-1:0] HB_ONE     = HW'(1);
  localparam logic [HW-1:0] HB_INIT    = HW'(HANDBACK_CYC);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    LOAD     = 2'd1,
    HANDBACK = 2'd2
  } state_t;

  state_t          state_r;
  logic [BW-1:0]   burst_cnt_r;
  logic [HW-1:0]   hb_cnt_r;
  logic            gnt_s;
  logic [BW-1:0]   burst_nxt_s;

  // Loader wins the port unless in reset or in the reserved fetch window.
  always_comb begin
    gnt_s       = 1'b0;
    burst_nxt_s = burst_cnt_r + BURST_ONE;
    if (!rst && ld_req && (state_r != HANDBACK)) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  assign ld_gnt     = gnt_s;
  assign arb_stall  = gnt_s;
  assign mem_addr   = gnt_s ? ld_addr : fetch_addr;
  assign mem_wren   = gnt_s & ld_we;
  assign mem_wdata  = ld_wdata;
  assign fetch_data = mem_q;
  assign ld_rdata   = mem_q;

  // Burst-limiting FSM and the one-cycle read-return valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FETCH;
      burst_cnt_r <= BURST_ZERO;
      hb_cnt_r    <= HB_ZERO;
      fetch_valid <= 1'b0;
      ld_rvalid   <= 1'b0;
    end else begin
      fetch_valid <= fetch_en & ~gnt_s;
      ld_rvalid   <= gnt_s & ~ld_we;
      case (state_r)
        FETCH: begin
          if (gnt_s) begin
            burst_cnt_r <= BURST_ONE;
            if (BURST_ONE >= BURST_MAX) begin
              state_r  <= HANDBACK;
              hb_cnt_r <= HB_INIT;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            burst_cnt_r <= BURST_ZERO;
          end
        end
        LOAD: begin
          if (gnt_s) begin
            burst_cnt_r <= burst_nxt_s;
            if (burst_nxt_s >= BURST_MAX) begin
              state_r  <= HANDBACK;
              hb_cnt_r <= HB_INIT;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            // a single idle cycle ends the burst
            state_r     <= FETCH;
            burst_cnt_r <= BURST_ZERO;
          end
        end
        HANDBACK: begin
          if (hb_cnt_r <= HB_ONE) begin
            state_r     <= FETCH;
            burst_cnt_r <= BURST_ZERO;
            hb_cnt_r    <= HB_ZERO;
          end else begin
            hb_cnt_r <= hb_cnt_r - HB_ONE;
          end
        end
        default: begin
          state_r     <= FETCH;
          burst_cnt_r <= BURST_ZERO;
          hb_cnt_r    <= HB_ZERO;
        end
      endcase
    end
  end

endmodule
